hbm_req_arbiter: RTL and testbench

- Shares the single HBM command/data port of memory_controler between NUM_REQ pipeline requesters, e.g. stage-2 operand fetch, stage-6 accumulator writeback and prefetch.
- Uses round-robin arbitration, granting one whole burst at a time.
- Latches the winner's command, presents it to the memory controller, then steers write or read data beats to and from the granted requester until the burst completes.
- Sits between the pipe stages and memory_controler.

---
 rtl/hbm_req_arbiter.sv | 132 +++++++++++++
 tb/tb_hbm_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_req_arbiter.sv
// Round-robin arbiter sharing the single HBM command/data port among NUM_REQ requesters.
// One whole burst is owned at a time: latch the winner's command, issue it, then steer its beats.
module hbm_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 256
) (
  input  logic                        CLK_i,
  input  logic                        RST_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  input  logic [NUM_REQ-1:0]          wvalid_i,
  output logic [NUM_REQ-1:0]          wready_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  input  logic [NUM_REQ-1:0]          rready_i,
  output logic                        mc_cmd_valid_o,
  input  logic                        mc_cmd_ready_i,
  output logic                        mc_cmd_we_o,
  output logic [ADDR_W-1:0]           mc_cmd_addr_o,
  output logic [LEN_W-1:0]            mc_cmd_len_o,
  output logic [DATA_W-1:0]           mc_wdata_o,
  output logic                        mc_wvalid_o,
  input  logic                        mc_wready_i,
  input  logic [DATA_W-1:0]           mc_rdata_i,
  input  logic                        mc_rvalid_i,
  output logic                        mc_rready_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  grant_idx, last_idx, pick_idx, cand;
  logic              pick_found;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [LEN_W:0]    beat_cnt;
  logic              wr_active, rd_active, beat, last_beat;

  // Search upward from the requester after the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_idx) + i) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wr_active = (state == DATA) && cmd_we;
  assign rd_active = (state == DATA) && !cmd_we;
  assign beat      = wr_active ? (mc_wvalid_o && mc_wready_i)
                               : (rd_active && mc_rvalid_i && mc_rready_o);
  assign last_beat = beat && (beat_cnt == {1'b0, cmd_len});

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found)     state_nxt = CMD;
      CMD:     if (mc_cmd_ready_i) state_nxt = DATA;
      DATA:    if (last_beat)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= IDX_W'(NUM_REQ - 1);
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) grant_idx <= pick_idx;
      if (state == CMD && mc_cmd_ready_i) beat_cnt <= '0;
      else if (beat)                      beat_cnt <= beat_cnt + {{LEN_W{1'b0}}, 1'b1};
      if (last_beat) last_idx <= grant_idx;
    end
  end

  // Command fields only matter once CMD is entered, so they carry no reset.
  always_ff @(posedge CLK_i) begin
    if (state == IDLE && pick_found) begin
      cmd_we   <= req_we_i[pick_idx];
      cmd_addr <= req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
      cmd_len  <= req_len_i[int'(pick_idx)*LEN_W +: LEN_W];
    end
  end

  assign mc_cmd_valid_o = (state == CMD);
  assign mc_cmd_we_o    = (state == CMD) && cmd_we;
  assign mc_cmd_addr_o  = (state == CMD) ? cmd_addr : '0;
  assign mc_cmd_len_o   = (state == CMD) ? cmd_len  : '0;
  assign busy_o         = (state != IDLE);

  // Read beats arriving outside DATA are a controller error and are simply dropped.
  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    wready_o    = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    mc_wdata_o  = '0;
    mc_wvalid_o = 1'b0;
    mc_rready_o = 1'b0;
    if (state != IDLE) grant_o[grant_idx] = 1'b1;
    if (state == CMD)  req_ready_o[grant_idx] = mc_cmd_ready_i;
    if (wr_active) begin
      mc_wdata_o          = wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
      mc_wvalid_o         = wvalid_i[grant_idx];
      wready_o[grant_idx] = mc_wready_i;
    end
    if (rd_active) begin
      rdata_o             = mc_rdata_i;
      rvalid_o[grant_idx] = mc_rvalid_i;
      mc_rready_o         = rready_i[grant_idx];
    end
  end
endmodule

// File: tb/tb_hbm_req_arbiter.sv
// Randomized bench for hbm_req_arbiter: a round-robin order model fills a scoreboard,
// and a monitor checks commands and every data beat against it.
`timescale 1ns/1ps
module tb_hbm_req_arbiter;
  localparam int N = 4, AW = 32, LW = 8, DW = 256, MAXB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, wvalid, wready, rvalid, rready, grant;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mc_wdata, mc_rdata;
  logic            mc_cmd_valid, mc_cmd_ready, mc_cmd_we, mc_wvalid, mc_wready;
  logic            mc_rvalid, mc_rready, busy;
  logic [AW-1:0]   mc_cmd_addr;
  logic [LW-1:0]   mc_cmd_len;

  hbm_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
    .CLK_i(clk), .RST_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_ready_o(req_ready), .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready),
    .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .mc_cmd_valid_o(mc_cmd_valid), .mc_cmd_ready_i(mc_cmd_ready), .mc_cmd_we_o(mc_cmd_we),
    .mc_cmd_addr_o(mc_cmd_addr), .mc_cmd_len_o(mc_cmd_len),
    .mc_wdata_o(mc_wdata), .mc_wvalid_o(mc_wvalid), .mc_wready_i(mc_wready),
    .mc_rdata_i(mc_rdata), .mc_rvalid_i(mc_rvalid), .mc_rready_o(mc_rready),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            seq;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          fl;
  bit            fl_act, post_burst, drv_en, mon_en, timed_out;
  int            beats, rr, cmd_hold, checks, errors;
  bit            b_we[N][MAXB];
  logic [AW-1:0] b_addr[N][MAXB];
  logic [LW-1:0] b_len[N][MAXB];
  int            b_n[N], req_idx[N], dat_seq[N], dat_beat[N];
  bit            dat_active[N], dat_we[N];
  bit            prev_wait, prev_we;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_len;

  function automatic logic [DW-1:0] wfun(input int k, input int j, input int b);
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = 32'h5a00_0000 ^ 32'((k << 24) ^ (j << 16) ^ (b << 4) ^ i);
    return w;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Every requester with bursts left is requesting at each arbitration point.
  task automatic plan();
    int   rem[N];
    int   pick;
    bit   found;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      rem[k] = b_n[k];
      req_idx[k] = 0;
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      pick = 0;
      for (int i = 1; i <= N; i++)
        if (!found && rem[(rr + i) % N] > 0) begin
          found = 1'b1;
          pick = (rr + i) % N;
        end
      if (found) begin
        e.id = pick; e.we = b_we[pick][b_n[pick]-rem[pick]];
        e.addr = b_addr[pick][b_n[pick]-rem[pick]]; e.len = b_len[pick][b_n[pick]-rem[pick]];
        e.seq = b_n[pick] - rem[pick];
        rem[pick]--;
        rr = pick;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_cycle();
    for (int k = 0; k < N; k++) begin
      if (req_idx[k] < b_n[k]) begin
        req_valid[k] = 1'b1;
        req_we[k] = b_we[k][req_idx[k]];
        req_addr[k*AW +: AW] = b_addr[k][req_idx[k]];
        req_len[k*LW +: LW] = b_len[k][req_idx[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_we[k] = 1'($urandom);
        req_addr[k*AW +: AW] = $urandom;
        req_len[k*LW +: LW] = LW'($urandom);
      end
      if (dat_active[k] && dat_we[k]) begin
        wvalid[k] = ($urandom % 4) != 0;
        wdata[k*DW +: DW] = wfun(k, dat_seq[k], dat_beat[k]);
      end else begin
        wvalid[k] = 1'($urandom);
        wdata[k*DW +: DW] = rnd256();
      end
      rready[k] = ($urandom % 4) != 0;
    end
    if (cmd_hold > 0) begin
      mc_cmd_ready = 1'b0;
      cmd_hold--;
    end else mc_cmd_ready = ($urandom % 10) < 7;
    mc_wready = ($urandom % 10) < 6;
    mc_rvalid = (fl_act && !fl.we) ? (($urandom % 10) < 7) : (($urandom % 10) == 0);
    mc_rdata  = rnd256();
  endtask

  task automatic monitor_cycle();
    logic [N-1:0] g;
    exp_t e;
    if (mc_rvalid && !(fl_act && !fl.we)) chk("rvalid_drop", {rvalid, mc_rready}, '0);
    if (fl_act) begin
      g = oh(fl.id);
      chk("grant_hold", {busy, grant}, {1'b1, g});
      if (fl.we) begin
        chk("wready", wready, mc_wready ? g : '0);
        chk("wvalid_mux", mc_wvalid, wvalid[fl.id]);
        if (wvalid[fl.id] && mc_wready) begin
          chk("wdata", mc_wdata, wfun(fl.id, fl.seq, beats));
          beats++;
          dat_beat[fl.id]++;
        end
      end else begin
        chk("rvalid", rvalid, mc_rvalid ? g : '0);
        chk("rready_mux", mc_rready, rready[fl.id]);
        if (mc_rvalid) chk("rdata", rdata, mc_rdata);
        if (mc_rvalid && rready[fl.id]) beats++;
      end
      if (beats == int'(fl.len) + 1) begin
        fl_act = 1'b0;
        dat_active[fl.id] = 1'b0;
        post_burst = 1'b1;
      end
    end else if (post_burst) begin
      chk("idle_bubble", {busy, grant}, '0);
      post_burst = 1'b0;
    end
    if (mc_cmd_valid) begin
      if (prev_wait)
        chk("cmd_stable", {mc_cmd_we, mc_cmd_addr, mc_cmd_len}, {prev_we, prev_addr, prev_len});
      if (mc_cmd_ready) begin
        prev_wait = 1'b0;
        if (fl_act || exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got grant %0h addr %0h, required no command", grant, mc_cmd_addr);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_fields", {grant, mc_cmd_we, mc_cmd_addr, mc_cmd_len}, {oh(e.id), e.we, e.addr, e.len});
          chk("req_ready", req_ready, oh(e.id));
          fl = e; fl_act = 1'b1; beats = 0;
          dat_active[e.id] = 1'b1; dat_we[e.id] = e.we; dat_seq[e.id] = e.seq; dat_beat[e.id] = 0;
          req_idx[e.id]++;
        end
      end else begin
        chk("req_ready_wait", req_ready, '0);
        prev_wait = 1'b1; prev_we = mc_cmd_we; prev_addr = mc_cmd_addr; prev_len = mc_cmd_len;
      end
    end else begin
      prev_wait = 1'b0;
      chk("req_ready_idle", req_ready, '0);
    end
  endtask

  task automatic driver_loop();
    forever begin
      @(negedge clk);
      if (drv_en) drive_cycle();
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) monitor_cycle();
    end
  endtask

  task automatic run_phase(input int budget);
    int cyc;
    cyc = 0;
    plan();
    while ((exp_q.size() != 0 || fl_act || post_burst) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      timed_out = 1'b1;
      $display("FAIL phase_timeout: %0d bursts still pending after %0d cycles", exp_q.size(), cyc);
    end
    for (int k = 0; k < N; k++) b_n[k] = 0;
  endtask

  task automatic set_burst(input int k, input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    b_we[k][b_n[k]] = we;
    b_addr[k][b_n[k]] = addr;
    b_len[k][b_n[k]] = len;
    b_n[k]++;
  endtask

  task automatic outs_zero(input string name);
    chk(name, $countones({req_ready, wready, rdata, rvalid, mc_cmd_valid, mc_cmd_we, mc_cmd_addr,
                          mc_cmd_len, mc_wdata, mc_wvalid, mc_rready, grant, busy}), '0);
  endtask

  initial begin
    checks = 0; errors = 0; drv_en = 0; mon_en = 0; timed_out = 0; cmd_hold = 0;
    fl_act = 0; post_burst = 0; prev_wait = 0; beats = 0;
    for (int k = 0; k < N; k++) begin
      b_n[k] = 0; req_idx[k] = 0; dat_active[k] = 0; dat_we[k] = 0; dat_seq[k] = 0; dat_beat[k] = 0;
    end
    rst = 1'b1;
    req_valid = 4'b0110; req_we = '0; req_addr = '0; req_len = '0;
    wdata = '0; wvalid = '1; rready = '1;
    mc_cmd_ready = 1'b1; mc_wready = 1'b1; mc_rdata = '1; mc_rvalid = 1'b1;
    fork
      driver_loop();
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    outs_zero("reset_outputs");
    rst = 1'b0;
    req_valid = '0;
    rr = N - 1;
    drv_en = 1'b1;
    mon_en = 1'b1;

    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) set_burst(k, 1'b1, 32'h100 * (k + 1) + j, 8'd0);
    run_phase(2000);

    if (!timed_out) begin
      set_burst(1, 1'b0, 32'h0000_1000, 8'd3);
      cmd_hold = 8;
      run_phase(2000);
    end

    if (!timed_out) begin
      for (int j = 0; j < 6; j++)
        for (int k = 0; k < N; k++) set_burst(k, 1'($urandom), $urandom, LW'($urandom_range(0, 7)));
      set_burst(0, 1'b1, 32'h2000, 8'd2);
      run_phase(6000);
    end

    if (!timed_out) begin
      set_burst(2, 1'b0, 32'hABCD_0000, 8'd255);
      set_burst(3, 1'b1, 32'h4000, 8'd1);
      run_phase(6000);
    end

    if (!timed_out) begin
      drv_en = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      #1;
      req_valid = 4'b1000; req_we = '0;
      req_addr[3*AW +: AW] = 32'h3000; req_len[3*LW +: LW] = 8'd7;
      req_addr[0 +: AW] = 32'h0500; req_len[0 +: LW] = 8'd1;
      mc_cmd_ready = 1'b1; rready = '1; mc_rvalid = 1'b1; mc_wready = 1'b0; wvalid = '0;
      @(negedge clk);
      #1;
      chk("mid_cmd", {req_ready, mc_cmd_addr, mc_cmd_len}, {4'b1000, 32'h3000, 8'd7});
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("mid_beat0", rvalid, 4'b1000);
      repeat (2) @(negedge clk);
      #1;
      chk("mid_beat2", {busy, rvalid}, {1'b1, 4'b1000});
      rst = 1'b1;
      @(negedge clk);
      #1;
      outs_zero("mid_reset_outputs");
      rst = 1'b0;
      req_valid = 4'b1001;
      @(negedge clk);
      #1;
      chk("post_reset_grant", {grant, mc_cmd_valid, mc_cmd_addr, mc_cmd_len, req_ready},
          {4'b0001, 1'b1, 32'h0500, 8'd1, 4'b0001});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
